// File: rtl/fp16_pkg.sv
// Shared binary16 format definitions for the PE datapath.
// Holds field widths, special-value encodings, the packed fp16 layout and
// a helper that unpacks an operand and classifies it as zero/inf/nan.
// Subnormal encodings (exp=0) classify as zero: the datapath flushes them.
package fp16_pkg;

   localparam int EXP_W  = 5;
   localparam int FRAC_W = 10;
   localparam int BIAS   = 15;

   localparam logic [15:0] QNAN    = 16'h7E00;
   localparam logic [15:0] POS_INF = 16'h7C00;
   localparam logic [15:0] NEG_INF = 16'hFC00;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } fp16_t;

   typedef struct packed {
      fp16_t f;
      logic  zero;
      logic  inf;
      logic  nan;
   } fp16_info_t;

   function automatic fp16_info_t fp16_unpack(input logic [15:0] x);
      fp16_info_t r;
      r.f    = fp16_t'(x);
      r.zero = (r.f.exp == '0);
      r.inf  = (&r.f.exp) && (r.f.frac == '0);
      r.nan  = (&r.f.exp) && (r.f.frac != '0);
      return r;
   endfunction

endpackage

// File: rtl/fp16_lzc.sv
// 14-bit leading-zero counter for the subtract-normalize step.
// Ports:
//   d   in  14  value to scan (bit 13 is the most significant)
//   cnt out  4  number of leading zeros; 14 when d is all zero
module fp16_lzc (
   input  logic [13:0] d,
   output logic [3:0]  cnt
);

   // Scanning upward lets the highest set bit win.
   always_comb begin
      cnt = 4'd14;
      for (int i = 0; i < 14; i++) begin
         if (d[i]) cnt = 4'(13 - i);
      end
   end

endmodule

// File: rtl/fp16_adder.sv
// IEEE-754 binary16 adder, round-to-nearest-even, flush-to-zero on
// subnormal inputs and on underflowing results. Combinational datapath
// with a single output register (latency 1, one result per cycle).
// Ports:
//   clk       in   1  clock
//   rst_n     in   1  async active-low reset
//   in_valid  in   1  operands valid this cycle
//   a, b      in  16  operands {sign, exp[4:0], frac[9:0]}
//   out_valid out  1  sum holds the result of the previous cycle's operands
//   sum       out 16  registered result
module fp16_adder
   import fp16_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        out_valid,
   output logic [15:0] sum
);

   fp16_info_t        ia, ib;
   logic              a_big;
   fp16_t             big, sml;
   logic [EXP_W-1:0]  exp_diff;
   logic [25:0]       align_sh;
   logic [13:0]       mant_big, mant_sml;
   logic              eff_sub;
   logic [14:0]       add_raw;
   logic [13:0]       sub_raw;
   logic [3:0]        lz;
   logic [13:0]       norm_m;
   logic signed [6:0] norm_e;
   logic              rnd_up;
   logic [11:0]       rnd_m;
   logic signed [6:0] rnd_e;
   logic [FRAC_W-1:0] rnd_frac;
   logic [15:0]       res;

   assign ia = fp16_unpack(a);
   assign ib = fp16_unpack(b);

   assign a_big    = {ia.f.exp, ia.f.frac} >= {ib.f.exp, ib.f.frac};
   assign big      = a_big ? ia.f : ib.f;
   assign sml      = a_big ? ib.f : ia.f;
   assign exp_diff = big.exp - sml.exp;
   assign eff_sub  = big.sign ^ sml.sign;

   // Working mantissa: {hidden, frac[9:0], guard, round, sticky}.
   // The lower 13 bits of align_sh catch everything shifted past round.
   assign align_sh = {1'b1, sml.frac, 2'b00, 13'b0} >> exp_diff;
   assign mant_big = {1'b1, big.frac, 3'b000};
   assign mant_sml = (exp_diff >= 5'd14) ? 14'd1
                                         : {align_sh[25:13], |align_sh[12:0]};

   assign add_raw = {1'b0, mant_big} + {1'b0, mant_sml};
   assign sub_raw = mant_big - mant_sml;

   fp16_lzc u_lzc (
      .d   (sub_raw),
      .cnt (lz)
   );

   always_comb begin
      norm_e = $signed({2'b00, big.exp});
      norm_m = add_raw[13:0];
      if (!eff_sub) begin
         if (add_raw[14]) begin
            norm_m = {add_raw[14:2], add_raw[1] | add_raw[0]};
            norm_e = norm_e + 7'sd1;
         end
      end else begin
         norm_m = sub_raw << lz;
         norm_e = norm_e - $signed({3'b000, lz});
      end
   end

   // Ties-to-even: round up on guard when round/sticky or the kept LSB is set.
   assign rnd_up   = norm_m[2] & (norm_m[1] | norm_m[0] | norm_m[3]);
   assign rnd_m    = {1'b0, norm_m[13:3]} + {11'b0, rnd_up};
   assign rnd_e    = rnd_m[11] ? norm_e + 7'sd1 : norm_e;
   assign rnd_frac = rnd_m[11] ? rnd_m[10:1] : rnd_m[9:0];

   always_comb begin
      res = {big.sign, rnd_e[EXP_W-1:0], rnd_frac};
      if (ia.nan || ib.nan || (ia.inf && ib.inf && (ia.f.sign != ib.f.sign)))
         res = QNAN;
      else if (ia.inf)
         res = a;
      else if (ib.inf)
         res = b;
      else if (ia.zero && ib.zero)
         res = {ia.f.sign & ib.f.sign, 15'b0};
      else if (ia.zero)
         res = b;
      else if (ib.zero)
         res = a;
      else if (eff_sub && (sub_raw == '0))
         res = 16'h0000;
      else if (rnd_e >= 7'sd31)
         res = big.sign ? NEG_INF : POS_INF;
      else if (rnd_e <= 7'sd0)
         res = {big.sign, 15'b0};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum       <= 16'h0000;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) sum <= res;
      end
   end

endmodule

// File: tb/tb_fp16_adder.sv
module tb_fp16_adder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        out_valid;
   logic [15:0] sum;

   int pass_cnt = 0;
   int total_cnt = 0;

   logic [15:0] exp_q[$];
   logic [15:0] last_exp = 16'h0000;

   fp16_adder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .sum       (sum)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      total_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, req);
   endtask

   // ---------------- reference model (real arithmetic) ----------------
   function automatic real pow2(input int n);
      real r;
      r = 1.0;
      if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
      else        for (int i = 0; i < -n; i++) r = r / 2.0;
      return r;
   endfunction

   function automatic real to_real(input logic [15:0] x);
      real m;
      m = 1.0 + real'(x[9:0]) / 1024.0;
      return (x[15] ? -m : m) * pow2(int'(x[14:10]) - 15);
   endfunction

   function automatic logic [15:0] model(input logic [15:0] x, input logic [15:0] y);
      logic   xn, yn, xi, yi, xz, yz, s;
      real    v, m, fl, rem;
      longint q;
      int     e, be;
      xn = (x[14:10] == 5'd31) && (x[9:0] != 0);
      yn = (y[14:10] == 5'd31) && (y[9:0] != 0);
      xi = (x[14:10] == 5'd31) && (x[9:0] == 0);
      yi = (y[14:10] == 5'd31) && (y[9:0] == 0);
      xz = (x[14:10] == 5'd0);
      yz = (y[14:10] == 5'd0);
      if (xn || yn) return 16'h7E00;
      if (xi && yi) return (x[15] == y[15]) ? x : 16'h7E00;
      if (xi) return x;
      if (yi) return y;
      if (xz && yz) return {x[15] & y[15], 15'b0};
      if (xz) return y;
      if (yz) return x;
      v = to_real(x) + to_real(y);
      if (v == 0.0) return 16'h0000;
      s = (v < 0.0);
      m = s ? -v : v;
      e = 0;
      while (m >= 2.0) begin m = m / 2.0; e++; end
      while (m < 1.0)  begin m = m * 2.0; e--; end
      m   = m * 1024.0;
      fl  = $floor(m);
      rem = m - fl;
      q   = longint'(fl);
      if (rem > 0.5 || (rem == 0.5 && q[0])) q++;
      if (q == 2048) begin q = 1024; e++; end
      be = e + 15;
      if (be >= 31) return s ? 16'hFC00 : 16'h7C00;
      if (be <= 0)  return {s, 15'b0};
      return {s, 5'(be), 10'(q - 1024)};
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [15:0] req);
      @(negedge clk);
      in_valid = 1'b1;
      a = x;
      b = y;
      exp_q.push_back(req);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
         a = $urandom;
         b = $urandom;
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic [15:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n) begin
            if (out_valid) begin
               if (exp_q.size() == 0) begin
                  total_cnt++;
                  $display("FAIL spurious_valid: out_valid=1 sum=%h with nothing expected", sum);
               end else begin
                  e = exp_q.pop_front();
                  check("sum", sum, e);
                  last_exp = e;
               end
            end else begin
               check("hold", sum, last_exp);
               if (exp_q.size() != 0) begin
                  total_cnt++;
                  $display("FAIL latency: out_valid=0 with %0d results pending", exp_q.size());
                  exp_q.delete();
               end
            end
         end
      end
   end

   // ---------------- directed + random stimulus ----------------
   logic [15:0] da[13] = '{16'h3C00, 16'h4000, 16'h3C00, 16'h4900, 16'hD640, 16'h56A0, 16'hE7E9,
                           16'hC000, 16'h8000, 16'h3C00, 16'h7BFF, 16'h7C00, 16'h0000};
   logic [15:0] db[13] = '{16'h4500, 16'h4400, 16'h4FC0, 16'h4D00, 16'h56E0, 16'hCD80, 16'h5EA0,
                           16'h4000, 16'h8000, 16'h1000, 16'h7BFF, 16'hFC00, 16'h8000};
   logic [15:0] de[13] = '{16'h4600, 16'h4600, 16'h5000, 16'h4F80, 16'h4900, 16'h5540, 16'hE641,
                           16'h0000, 16'h8000, 16'h3C00, 16'h7C00, 16'h7E00, 16'h0000};
   logic [15:0] spec[8] = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00,
                            16'h7E00, 16'h7D01, 16'h0123, 16'h3C00};

   initial begin
      logic [31:0] r1, r2;
      logic [15:0] x, y;
      int          ee;

      #1;
      check("rst_sum", sum, 16'h0000);
      check("rst_valid", {15'b0, out_valid}, 16'h0000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 13; i++) send(da[i], db[i], de[i]);
      idle(3);

      // Reset while a result is in flight: must clear immediately and drop it.
      send(16'h4900, 16'h4D00, 16'h4F80);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_sum", sum, 16'h0000);
      check("midrst_valid", {15'b0, out_valid}, 16'h0000);
      exp_q.delete();
      last_exp = 16'h0000;
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      for (int i = 0; i < 600; i++) begin
         r1 = $urandom;
         r2 = $urandom;
         x = r1[15:0];
         y = r1[31:16];
         if (r2[0]) begin
            ee = int'(x[14:10]) + int'(r2[4:1]) - 8;
            if (ee < 1)  ee = 1;
            if (ee > 30) ee = 30;
            y[14:10] = 5'(ee);
         end
         if (r2[7:5] == 3'd0)   x = spec[r2[10:8]];
         if (r2[13:11] == 3'd0) y = spec[r2[16:14]];
         send(x, y, model(x, y));
         if (r2[20:18] == 3'd0) idle(1 + int'(r2[21]));
      end
      idle(2);

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         total_cnt++;
         $display("FAIL drain: %0d results never appeared", exp_q.size());
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/fp16_adder.md
# fp16_adder

Single-cycle-latency IEEE-754 binary16 (half-precision) floating-point adder used in the processing element datapath. It adds two 16-bit operands and produces a 16-bit sum rounded to nearest-even. The arithmetic is combinational, and the result is registered once. The block feeds the PE accumulation path.

## Interface

Parameters:
- none; formats are fixed by the shared package.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `in_valid`  in  1  operands valid this cycle.
- `a`  in  16  operand A: {sign, exp[4:0], frac[9:0]}.
- `b`  in  16  operand B, same format.
- `out_valid`  out  1  `sum` holds the result of the operands presented one cycle earlier.
- `sum`  out  16  registered binary16 result.

## Operation

Format and special inputs:
- Exponent bias is 15. Hidden bit is 1 for exp 1..30.
- Subnormal inputs (exp=0) are treated as signed zero (flush-to-zero).
- Any NaN input produces the canonical qNaN 16'h7E00.
- +Inf + -Inf produces 16'h7E00.
- Inf + finite produces that Inf. Inf + same-signed Inf produces that Inf.

Finite path:
- Swap operands so the larger magnitude, compared on {exp, frac}, is the big operand.
- Align the small significand right by the exponent difference. Keep guard and round bits, plus a sticky bit (OR of all shifted-out bits). If the difference is ≥ 14, the small operand contributes only to sticky.
- Same signs: add the 11-bit significands. On carry-out, shift right by 1 (folding into sticky) and increment the exponent.
- Different signs: subtract small from big. Normalize left by the leading-zero count and decrement the exponent.
- Result sign is the sign of the big operand.
- Exact cancellation (e.g. −2 + 2) produces +0 = 16'h0000.
- Rounding is round-to-nearest, ties-to-even, using guard/round/sticky. If rounding carries out of the significand, renormalize and increment the exponent.
- Result exponent ≥ 31 produces signed Inf (exp=31, frac=0).
- Result exponent ≤ 0 flushes to signed zero.
- Zero + x returns x exactly. +0 + −0 produces +0. −0 + −0 produces −0.

## Timing

- Latency is 1 cycle. On each rising edge with `in_valid`=1: `sum` ← f(a, b) and `out_valid` ← 1.
- On an edge with `in_valid`=0, `out_valid` ← 0 and `sum` holds its previous value.
- Throughput is one operation per cycle. There is no backpressure.
- Reset values, applied immediately when `rst_n`=0 regardless of clock: `sum`=16'h0000, `out_valid`=0.
- Reset mid-operation discards the in-flight result.
- First valid result appears one edge after `rst_n` deasserts and `in_valid` is sampled high.

## Structure

- Package `fp16_pkg` holds:
  - widths: EXP_W=5, FRAC_W=10, BIAS=15
  - constants: QNAN=16'h7E00, POS_INF=16'h7C00, NEG_INF=16'hFC00
  - a packed struct `fp16_t` {sign, exp, frac}
  - a helper for field unpack/classification (zero/inf/nan).
- Sub-module `fp16_lzc`: 14-bit leading-zero counter used by the subtract-normalize step.
- The rest (swap, align, add/sub, normalize, round, special-case mux, output register) lives in `fp16_adder`.

## Test plan

- 16'h3C00 (1.0) + 16'h4500 (5.0) -> 16'h4600 (6.0). Also 16'h4000 + 16'h4400 -> 16'h4600.
- Carry renormalize: 16'h3C00 + 16'h4FC0 (31.0) -> 16'h5000. 16'h4900 (10) + 16'h4D00 (20) -> 16'h4F80.
- Mixed signs:
  - 16'hD640 (−100) + 16'h56E0 (110) -> 16'h4900.
  - 16'h56A0 (106) + 16'hCD80 (−22) -> 16'h5540.
  - 16'hE7E9 (−2025) + 16'h5EA0 (424) -> 16'hE641.
- Cancellation and zeros: 16'hC000 + 16'h4000 -> 16'h0000. 16'h8000 + 16'h8000 -> 16'h8000.
- Rounding/overflow:
  - 16'h3C00 + 16'h1000 -> 16'h3C00 (tie/sticky rounding, no change).
  - 16'h7BFF + 16'h7BFF -> 16'h7C00.
  - 16'h7C00 + 16'hFC00 -> 16'h7E00.
- Control:
  - `rst_n` low mid-stream -> `sum`=0 and `out_valid`=0 immediately.
  - Back-to-back `in_valid` -> one result per cycle, each 1 cycle late.
  - `in_valid` low -> `out_valid` low, `sum` held.
